fifo_write_ctrl: RTL and testbench

Write-side controller for the synchronous FIFO. It accepts write requests from the producer, gates them against a full condition, and issues the memory write strobe and address. It advances the write pointer that the read side and the empty comparator consume, and reports full, almost-full, occupancy and a sticky overflow error. It sits beside the FIFO storage array and is the write-end counterpart of the empty-flag comparator.

---
 rtl/fifo_write_ctrl.sv | 56 +++++
 tb/tb_fifo_write_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fifo_write_ctrl.sv
// Write-side controller for the synchronous FIFO: write pointer, write strobe,
// full/almost-full/occupancy reporting and a sticky overflow error.
module fifo_write_ctrl #(
    parameter int unsigned SIZE     = 4,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_req,
    input  logic [SIZE-1:0] r_pointer,
    input  logic            ovf_clr,
    output logic [SIZE-1:0] w_pointer,
    output logic [SIZE-2:0] w_addr,
    output logic            w_en,
    output logic            f_flag,
    output logic            af_flag,
    output logic [SIZE-1:0] count,
    output logic            ovf_flag
);

    localparam logic [SIZE-1:0] PTR_ONE   = SIZE'(1);
    localparam logic [SIZE-1:0] AF_THRESH = SIZE'(AF_LEVEL);

    logic refused;

    always_comb begin
        f_flag  = (w_pointer[SIZE-1] != r_pointer[SIZE-1]) &&
                  (w_pointer[SIZE-2:0] == r_pointer[SIZE-2:0]);
        count   = w_pointer - r_pointer;
        af_flag = (count >= AF_THRESH);
        // Strobe is held off while rst is high so the memory is never written during reset.
        w_en    = w_req && !f_flag && !rst;
        refused = w_req && f_flag;
        w_addr  = w_pointer[SIZE-2:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_pointer <= '0;
        end else if (w_en) begin
            w_pointer <= w_pointer + PTR_ONE;
        end
    end

    // A new overflow on the same edge as ovf_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag <= 1'b0;
        end else if (refused) begin
            ovf_flag <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Table-driven bench for fifo_write_ctrl (SIZE=4, AF_LEVEL=6): each record drives
// inputs at the falling edge and checks outputs just after, before the next rising edge.
module tb_fifo_write_ctrl;

    localparam int unsigned SIZE = 4;

    logic            clk;
    logic            rst;
    logic            w_req;
    logic [SIZE-1:0] r_pointer;
    logic            ovf_clr;
    logic [SIZE-1:0] w_pointer;
    logic [SIZE-2:0] w_addr;
    logic            w_en;
    logic            f_flag;
    logic            af_flag;
    logic [SIZE-1:0] count;
    logic            ovf_flag;

    fifo_write_ctrl #(.SIZE(4), .AF_LEVEL(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_req     (w_req),
        .r_pointer (r_pointer),
        .ovf_clr   (ovf_clr),
        .w_pointer (w_pointer),
        .w_addr    (w_addr),
        .w_en      (w_en),
        .f_flag    (f_flag),
        .af_flag   (af_flag),
        .count     (count),
        .ovf_flag  (ovf_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           label;
        logic            rst;
        logic            w_req;
        logic [SIZE-1:0] rp;
        logic            clr;
        logic            chk;   // 0: only w_en is defined (state not yet reset)
        logic            en;
        logic [SIZE-1:0] wp;
        logic [SIZE-1:0] cnt;
        logic            f;
        logic            af;
        logic            ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   step_no = 0;

    function automatic vec_t mk(input string label, input logic r, input logic wq,
                                input logic [SIZE-1:0] rp, input logic clr, input logic chk,
                                input logic en, input logic [SIZE-1:0] wp,
                                input logic [SIZE-1:0] cnt, input logic f, input logic af,
                                input logic ovf);
        vec_t v;
        v.label = label; v.rst = r; v.w_req = wq; v.rp = rp; v.clr = clr; v.chk = chk;
        v.en = en; v.wp = wp; v.cnt = cnt; v.f = f; v.af = af; v.ovf = ovf;
        return v;
    endfunction

    task automatic cmp(input vec_t v, input string field, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s#%0d %s: got %0d, want %0d", v.label, step_no, field, got, want);
    endtask

    task automatic step(input vec_t v);
        logic [SIZE-1:0] wp_exp;
        @(negedge clk);
        rst = v.rst; w_req = v.w_req; r_pointer = v.rp; ovf_clr = v.clr;
        #1;
        wp_exp = v.wp;
        cmp(v, "w_en", int'(w_en), int'(v.en));
        if (v.chk) begin
            cmp(v, "w_pointer", int'(w_pointer), int'(v.wp));
            cmp(v, "w_addr", int'(w_addr), int'(wp_exp[SIZE-2:0]));
            cmp(v, "count", int'(count), int'(v.cnt));
            cmp(v, "f_flag", int'(f_flag), int'(v.f));
            cmp(v, "af_flag", int'(af_flag), int'(v.af));
            cmp(v, "ovf_flag", int'(ovf_flag), int'(v.ovf));
        end
        step_no++;
    endtask

    initial begin
        rst = 1'b1; w_req = 1'b1; r_pointer = '0; ovf_clr = 1'b0;

        //                 label   rst wq  rp   clr chk en  wp  cnt  f  af ovf
        vecs.push_back(mk("reset", 1,  1,  0,   0,  0,  0,  0,  0,   0, 0, 0));
        vecs.push_back(mk("reset", 1,  1,  0,   0,  1,  0,  0,  0,   0, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk("fill", 0, 1, 0, 0, 1, 1, 4'(i), 4'(i), 0, (i >= 6), 0));
        vecs.push_back(mk("ovf",   0,  1,  0,   0,  1,  0,  8,  8,   1, 1, 0));
        vecs.push_back(mk("ovf",   0,  1,  0,   0,  1,  0,  8,  8,   1, 1, 1));
        vecs.push_back(mk("ovfclr",0,  0,  0,   1,  1,  0,  8,  8,   1, 1, 1));
        vecs.push_back(mk("ovfclr",0,  0,  0,   0,  1,  0,  8,  8,   1, 1, 0));
        // Each read frees one slot: one accepted write, then a refused one while full.
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk("drain", 0, 1, 4'(k), 0, 1, 1, 4'(7 + k), 7, 0, 1, (k > 1)));
            vecs.push_back(mk("drain", 0, 1, 4'(k), 0, 1, 0, 4'(8 + k), 8, 1, 1, (k > 1)));
        end

        foreach (vecs[i]) step(vecs[i]);

        // Simultaneous events at count = 3 (w_pointer 0, r_pointer 13).
        step(mk("simul", 0, 0, 13, 1, 1, 0, 0, 3, 0, 0, 1));
        step(mk("simul", 0, 1, 13, 0, 1, 1, 0, 3, 0, 0, 0));
        step(mk("simul", 0, 0, 14, 0, 1, 0, 1, 3, 0, 0, 0));
        step(mk("setwin", 0, 1, 9, 1, 1, 0, 1, 8, 1, 1, 0));
        step(mk("setwin", 0, 0, 9, 0, 1, 0, 1, 8, 1, 1, 1));

        // Reset in the middle of operation with count = 5 and the overflow flag still set.
        step(mk("midrst", 0, 1, 12, 0, 1, 1, 1, 5, 0, 0, 1));
        step(mk("midrst", 1, 1, 12, 0, 1, 0, 2, 6, 0, 1, 1));
        step(mk("midrst", 0, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0));
        step(mk("midrst", 0, 0, 0,  0, 1, 0, 1, 1, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
